// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard unit.
// Forwarding selects: FWD_NONE uses the ID/EX operand; values 2..NUM_STAGES name the source position.
package hazard_pkg;

    // rd is stored at this fixed width so the entry type does not depend on AW (AW <= HZ_RD_W)
    localparam int HZ_RD_W  = 8;
    localparam int FWD_NONE = 0;

    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight register writes (position 1 = ID/EX .. NUM_STAGES = MEM/WB)
// plus per-position source-operand match vectors.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW         = 5,
    parameter int NUM_STAGES = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_hold,
    input  logic                  i_bubble,
    input  sb_entry_t             i_entry,
    input  logic [AW-1:0]         i_rs1_addr,
    input  logic                  i_rs1_used,
    input  logic [AW-1:0]         i_rs2_addr,
    input  logic                  i_rs2_used,
    output logic [NUM_STAGES:1]   o_rs1_match,
    output logic [NUM_STAGES:1]   o_rs2_match,
    output logic [NUM_STAGES:1]   o_is_load,
    output logic                  o_entry1_valid
);

    sb_entry_t [NUM_STAGES:1] r_sb;

    logic               w_rs1_live;
    logic               w_rs2_live;
    logic [HZ_RD_W-1:0] w_rs1_ext;
    logic [HZ_RD_W-1:0] w_rs2_ext;

    assign w_rs1_ext  = HZ_RD_W'(i_rs1_addr);
    assign w_rs2_ext  = HZ_RD_W'(i_rs2_addr);
    // x0 reads are never hazards
    assign w_rs1_live = i_rs1_used && (i_rs1_addr != '0);
    assign w_rs2_live = i_rs2_used && (i_rs2_addr != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sb <= '0;
        end else if (!i_hold) begin
            r_sb[1] <= i_bubble ? '0 : i_entry;
            for (int p = 2; p <= NUM_STAGES; p++) begin
                r_sb[p] <= r_sb[p-1];
            end
        end
    end

    for (genvar p = 1; p <= NUM_STAGES; p++) begin : g_pos
        assign o_rs1_match[p] = w_rs1_live && r_sb[p].valid && (r_sb[p].rd == w_rs1_ext);
        assign o_rs2_match[p] = w_rs2_live && r_sb[p].valid && (r_sb[p].rd == w_rs2_ext);
        assign o_is_load[p]   = r_sb[p].is_load;
    end

    assign o_entry1_valid = r_sb[1].valid;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stalls, EX forwarding selects, WB->ID bypass,
// jump flushes and stall/flush cycle counters, all driven from the write scoreboard.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter  int AW         = 5,
    parameter  int NUM_STAGES = 3,
    parameter  int ALU_AVAIL  = 2,
    parameter  int LOAD_AVAIL = 3,
    parameter  int FWD_EN     = 1,
    parameter  int CNT_W      = 32,
    localparam int SW         = $clog2(NUM_STAGES + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_hold,
    input  logic             i_id_valid,
    input  logic [AW-1:0]    i_id_rs1_addr,
    input  logic             i_id_rs1_used,
    input  logic [AW-1:0]    i_id_rs2_addr,
    input  logic             i_id_rs2_used,
    input  logic [AW-1:0]    i_id_rd_addr,
    input  logic             i_id_rf_wen,
    input  logic             i_id_is_load,
    input  logic             i_ex_jump,
    output logic             o_stall,
    output logic             o_flush,
    output logic             o_id_wb_byp_rs1,
    output logic             o_id_wb_byp_rs2,
    output logic [SW-1:0]    o_ex_fwd_sel_rs1,
    output logic [SW-1:0]    o_ex_fwd_sel_rs2,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic [1:0][NUM_STAGES:1] w_match;
    logic [NUM_STAGES:1]      w_is_load;
    logic [NUM_STAGES:1]      w_rs1_match;
    logic [NUM_STAGES:1]      w_rs2_match;
    logic                     w_entry1_valid;
    sb_entry_t                w_entry;
    logic                     w_stall;
    logic                     w_flush;
    logic                     w_any_stall;

    logic [SW-1:0]    r_sel_rs1;
    logic [SW-1:0]    r_sel_rs2;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_entry.valid   = i_id_valid && i_id_rf_wen && (i_id_rd_addr != '0);
    assign w_entry.rd      = HZ_RD_W'(i_id_rd_addr);
    assign w_entry.is_load = i_id_is_load;

    hazard_scoreboard #(
        .AW         (AW),
        .NUM_STAGES (NUM_STAGES)
    ) u_sb (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_hold         (i_hold),
        .i_bubble       (w_stall || w_flush),
        .i_entry        (w_entry),
        .i_rs1_addr     (i_id_rs1_addr),
        .i_rs1_used     (i_id_rs1_used),
        .i_rs2_addr     (i_id_rs2_addr),
        .i_rs2_used     (i_id_rs2_used),
        .o_rs1_match    (w_rs1_match),
        .o_rs2_match    (w_rs2_match),
        .o_is_load      (w_is_load),
        .o_entry1_valid (w_entry1_valid)
    );

    assign w_match[0] = w_rs1_match;
    assign w_match[1] = w_rs2_match;

    for (genvar op = 0; op < 2; op++) begin : g_op
        logic          w_hit;
        logic          w_load;
        logic [SW-1:0] w_pos;
        logic          w_op_stall;
        logic          w_op_byp;
        logic [SW-1:0] w_sel;

        // Scan oldest to youngest so the youngest producer overwrites
        always_comb begin
            w_hit  = 1'b0;
            w_pos  = '0;
            w_load = 1'b0;
            for (int p = NUM_STAGES; p >= 1; p--) begin
                if (w_match[op][p]) begin
                    w_hit  = 1'b1;
                    w_pos  = SW'(p);
                    w_load = w_is_load[p];
                end
            end
        end

        // Producer at p is at p+1 once this consumer reaches EX
        always_comb begin
            w_op_stall = 1'b0;
            w_op_byp   = 1'b0;
            w_sel      = SW'(FWD_NONE);
            if (w_hit) begin
                if (w_pos == SW'(NUM_STAGES)) begin
                    w_op_byp = 1'b1;
                end else if (FWD_EN == 0) begin
                    w_op_stall = 1'b1;
                end else if ((int'(w_pos) + 1) < (w_load ? LOAD_AVAIL : ALU_AVAIL)) begin
                    w_op_stall = 1'b1;
                end else begin
                    w_sel = w_pos + SW'(1);
                end
            end
        end
    end

    assign w_any_stall = g_op[0].w_op_stall || g_op[1].w_op_stall;
    assign w_flush     = i_ex_jump && w_entry1_valid;
    assign w_stall     = i_id_valid && w_any_stall && !w_flush;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sel_rs1   <= SW'(FWD_NONE);
            r_sel_rs2   <= SW'(FWD_NONE);
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!i_hold) begin
            if (w_stall || w_flush || !i_id_valid) begin
                r_sel_rs1 <= SW'(FWD_NONE);
                r_sel_rs2 <= SW'(FWD_NONE);
            end else begin
                r_sel_rs1 <= g_op[0].w_sel;
                r_sel_rs2 <= g_op[1].w_sel;
            end
            if (w_stall) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_stall          = w_stall;
    assign o_flush          = w_flush;
    assign o_id_wb_byp_rs1  = g_op[0].w_op_byp;
    assign o_id_wb_byp_rs2  = g_op[1].w_op_byp;
    assign o_ex_fwd_sel_rs1 = r_sel_rs1;
    assign o_ex_fwd_sel_rs2 = r_sel_rs2;
    assign o_stall_cnt      = r_stall_cnt;
    assign o_flush_cnt      = r_flush_cnt;

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised pipeline-control block for the in-order RISC-V pipeline. Replaces ad-hoc stall-on-any-match hazard logic.
- Keeps a scoreboard shift register of in-flight register writes, one entry per pipeline position after ID.
- From the scoreboard it decides load-use stalls, per-operand forwarding selects, WB-to-ID bypass and jump flushes.
- Also counts stall and flush cycles.

Parameters:
- AW, 5, register-address width (2**AW architectural registers; x0 never hazards).
- NUM_STAGES, 3, pipeline positions after ID: 1 = ID/EX, 2 = EX/MEM, ..., NUM_STAGES = MEM/WB (the entry writing the RF this cycle).
- ALU_AVAIL, 2, first position whose pipeline register holds a non-load result.
- LOAD_AVAIL, 3, first position holding load data; must satisfy ALU_AVAIL <= LOAD_AVAIL <= NUM_STAGES.
- FWD_EN, 1, 1 = forwarding mode, 0 = stall-only mode.
- CNT_W, 32, performance-counter width.

Ports:
- clk in 1: clock.
- reset in 1: synchronous, active-high reset.
- hold in 1: external freeze of the whole pipeline (memory wait).
- id_valid in 1: ID stage holds a real instruction.
- id_rs1_addr in AW: ID source-1 register address.
- id_rs1_used in 1: ID instruction reads rs1.
- id_rs2_addr in AW: ID source-2 register address.
- id_rs2_used in 1: ID instruction reads rs2.
- id_rd_addr in AW: ID destination register.
- id_rf_wen in 1: ID instruction writes rd.
- id_is_load in 1: ID instruction is a load.
- ex_jump in 1: instruction at position 1 resolved a taken jump/branch.
- stall out 1: hold PC and IF/ID; inject a bubble into ID/EX.
- flush out 1: squash IF/ID and the ID instruction.
- id_wb_byp_rs1 out 1: substitute the RF write value for rs1 at ID.
- id_wb_byp_rs2 out 1: substitute the RF write value for rs2 at ID.
- ex_fwd_sel_rs1 out SW: registered forwarding select for the EX operand; SW = $clog2(NUM_STAGES+1).
- ex_fwd_sel_rs2 out SW: as above, for rs2.
- stall_cnt out CNT_W: count of stall cycles.
- flush_cnt out CNT_W: count of flush cycles.

Behaviour:
- Scoreboard entry: {valid, rd, is_load}. Entry p describes the instruction at position p.
- Match at p: entry valid, its rd equals a used source address, and that address != 0.
- Youngest (smallest p) match wins per operand.
- Each non-hold cycle all entries shift p -> p+1; entry NUM_STAGES retires.
- Entry 1 is loaded as follows:
  - flush: bubble.
  - else stall: bubble.
  - else: {id_valid & id_rf_wen & id_rd_addr != 0, id_rd_addr, id_is_load}.
- Per-operand decision, FWD_EN = 1, for a youngest match at p:
  - p == NUM_STAGES: id_wb_byp asserted, no stall.
  - else: producer sits at p+1 when the consumer is in EX.
    - If p+1 < avail (avail = LOAD_AVAIL for loads, ALU_AVAIL otherwise): stall.
    - Otherwise the next ex_fwd_sel = p+1.
  - No match: ex_fwd_sel = 0 (use the ID/EX operand).
- FWD_EN = 0: any match at p < NUM_STAGES stalls. A match at p == NUM_STAGES uses id_wb_byp. ex_fwd_sel stays 0.
- stall is combinational: id_valid & any operand stall & !flush.
- flush is combinational: ex_jump & entry1.valid. Flush has priority over stall.
- ex_fwd_sel registers update on non-hold cycles:
  - 0 when stall, flush or !id_valid.
  - otherwise the computed selects.
- hold:
  - Scoreboard, ex_fwd_sel and counters are frozen.
  - stall, flush and id_wb_byp stay combinational.
  - A pending ex_jump remains visible after hold releases.
- Counters wrap at 2**CNT_W.
  - stall_cnt increments on non-hold cycles with stall.
  - flush_cnt increments on non-hold cycles with flush.
- Reset (synchronous; overrides hold): all entries invalid, ex_fwd_sel = 0, both counters 0. Hence stall = flush = byp = 0 on the following cycle.
- Reset mid-flight discards every tracked write.

Decomposition:
- Package hazard_pkg: fwd-select encodings (FWD_NONE = 0; positions 2..NUM_STAGES) and the sb_entry_t typedef {valid, rd, is_load}.
- Sub-module hazard_scoreboard: shift register, hold/bubble insertion, per-position match vectors.
- hazard_unit itself: priority-match, stall/flush/fwd logic and counters.

Test Plan:
- ALU hazard:
  - Stimulus: add x5 enters (rd=5); next cycle ID reads rs1=5, FWD_EN=1.
  - Required: stall=0; ex_fwd_sel_rs1=2 the following cycle.
- Load-use hazard:
  - Stimulus: lw x7; next cycle ID reads rs2=7.
  - Required: stall=1 for exactly 1 cycle, stall_cnt=1; after the bubble, ex_fwd_sel_rs2=3.
- WB bypass and x0:
  - Stimulus A: producer rd=9 reaches position 3 while ID reads rs1=9. Required: id_wb_byp_rs1=1, stall=0.
  - Stimulus B: rd=0 producer with ID reading x0. Required: no stall, no forwarding.
- Stall-only mode:
  - Stimulus: FWD_EN=0; add x3, then ID reads x3.
  - Required: stall=1 for 2 cycles, then id_wb_byp_rs1=1; stall_cnt=2.
- Jump flush vs stall:
  - Stimulus: ex_jump=1 with entry1 valid while ID has a load-use hazard.
  - Required: flush=1, stall=0, entry1 next = bubble, flush_cnt increments by 1, stall_cnt unchanged.
- Hold and reset:
  - Stimulus A: hold=1 for 3 cycles mid-hazard. Required: selects and counters frozen.
  - Stimulus B: reset asserted with 3 valid entries. Required: next cycle all outputs 0, counters 0.
